// File: rtl/xor_prng_pkg.sv
// xor_prng_pkg
//   Shared definitions for the xorshift32 generator bank: state type, shift
//   constants, golden-ratio seed spreader and the step / zero-guard helpers.
//   Imported by xor_prng_lane and xor_prng_bank.
package xor_prng_pkg;

    typedef logic [31:0] prng_state_t;

    localparam int unsigned XS_SHL_A = 13;
    localparam int unsigned XS_SHR_B = 17;
    localparam int unsigned XS_SHL_C = 5;

    // Spreads the base seed across channels so lanes start far apart.
    localparam prng_state_t PRNG_GOLDEN = 32'h9E37_79B9;

    // One xorshift32 step; shifts discard overflow on 32 bits.
    function automatic prng_state_t xs32_next(input prng_state_t x);
        prng_state_t y;
        y = x ^ (x << XS_SHL_A);
        y = y ^ (y >> XS_SHR_B);
        y = y ^ (y << XS_SHL_C);
        return y;
    endfunction

    // Zero is the one fixed point of xorshift32; it must never be loaded.
    function automatic prng_state_t xs32_nz(input prng_state_t x);
        return (x == '0) ? 32'h0000_0001 : x;
    endfunction

    // Register value a channel takes on reset.
    function automatic prng_state_t xs32_reset_state(input prng_state_t seed,
                                                     input int unsigned ch);
        return xs32_next(xs32_nz(seed ^ (prng_state_t'(ch) * PRNG_GOLDEN)));
    endfunction

endpackage

// File: rtl/xor_prng_lane.sv
// xor_prng_lane
//   One xorshift32 channel: state register, valid register, advance / reseed
//   mux and output slice.
// Parameters
//   OUT_W        output width, top OUT_W bits of the state
//   RESET_STATE  state loaded on reset
//   FREE_RUN     1: advance whenever valid and enable; 0: advance on valid&ready
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   enable       global run enable (also the next value of valid)
//   ready        consumer ready for this channel
//   load         reseed strobe already decoded for this channel
//   seed_value   new seed (zero-guarded here)
//   valid        sample valid
//   data         sample, state[31 -: OUT_W]
module xor_prng_lane
    import xor_prng_pkg::*;
#(
    parameter int          OUT_W       = 12,
    parameter prng_state_t RESET_STATE = 32'h0004_2021,
    parameter bit          FREE_RUN    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             ready,
    input  logic             load,
    input  prng_state_t      seed_value,
    output logic             valid,
    output logic [OUT_W-1:0] data
);

    prng_state_t state_q;
    logic        valid_q;
    logic        advance;

    assign advance = valid_q && (FREE_RUN ? enable : ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RESET_STATE;
            valid_q <= 1'b0;
        end else begin
            valid_q <= enable;
            // A reseed wins over an advance landing on the same edge.
            if (load) begin
                state_q <= xs32_next(xs32_nz(seed_value));
            end else if (advance) begin
                state_q <= xs32_next(state_q);
            end
        end
    end

    assign valid = valid_q;
    assign data  = state_q[31 -: OUT_W];

endmodule

// File: rtl/xor_prng_bank.sv
// xor_prng_bank
//   NUM_CH independent xorshift32 generators, OUT_W bits per channel, with
//   run-time reseed and per-channel valid/ready.
// Parameters
//   NUM_CH (1-16), OUT_W (1-32), SEED (base reset seed), FREE_RUN (0/1)
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   enable                global run enable
//   seed_load, seed_ch    one-cycle reseed strobe and target channel
//   seed_value            new seed
//   rand_valid/rand_ready per-channel handshake
//   rand_data             channel c at [c*OUT_W +: OUT_W]
// Optional (macro XOR_PRNG_STATS_EN)
//   stat_clear            synchronous clear of the statistics
//   stat_count            accepted channel-0 samples, saturating
//   stat_sum              sum of accepted channel-0 samples, wrapping
//
// Handshake: rand_valid[c] is enable delayed by one cycle. A sample is
// accepted on an edge where rand_valid[c] && rand_ready[c] (FREE_RUN=0) or
// rand_valid[c] && enable (FREE_RUN=1, ready ignored); the next sample is
// visible right after that edge. With FREE_RUN=0 data holds while
// valid is high and ready is low.
module xor_prng_bank
    import xor_prng_pkg::*;
#(
    parameter int          NUM_CH   = 4,
    parameter int          OUT_W    = 12,
    parameter prng_state_t SEED     = 32'h0000_0001,
    parameter bit          FREE_RUN = 1'b0
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic                                            enable,
    input  logic                                            seed_load,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0]  seed_ch,
    input  logic [31:0]                                     seed_value,
    output logic [NUM_CH-1:0]                               rand_valid,
    input  logic [NUM_CH-1:0]                               rand_ready,
    output logic [NUM_CH*OUT_W-1:0]                         rand_data
`ifdef XOR_PRNG_STATS_EN
    ,
    input  logic                                            stat_clear,
    output logic [31:0]                                     stat_count,
    output logic [63:0]                                     stat_sum
`endif
);

    logic [NUM_CH-1:0] lane_load;

    // seed_ch values at or beyond NUM_CH match no lane, so the strobe is dropped.
    always_comb begin
        lane_load = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            lane_load[c] = seed_load && (int'(seed_ch) == c);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
        xor_prng_lane #(
            .OUT_W      (OUT_W),
            .RESET_STATE(xs32_reset_state(SEED, c)),
            .FREE_RUN   (FREE_RUN)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .enable    (enable),
            .ready     (rand_ready[c]),
            .load      (lane_load[c]),
            .seed_value(seed_value),
            .valid     (rand_valid[c]),
            .data      (rand_data[c*OUT_W +: OUT_W])
        );
    end

`ifdef XOR_PRNG_STATS_EN
    logic stat_accept;

    assign stat_accept = rand_valid[0] && (FREE_RUN ? enable : rand_ready[0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_count <= '0;
            stat_sum   <= '0;
        end else if (stat_clear) begin
            stat_count <= '0;
            stat_sum   <= '0;
        end else if (stat_accept) begin
            if (stat_count != '1) begin
                stat_count <= stat_count + 32'd1;
            end
            stat_sum <= stat_sum + 64'(rand_data[OUT_W-1:0]);
        end
    end
`endif

endmodule

// File: tb/tb_xor_prng_bank.sv
// tb_xor_prng_bank
//   Two banks share the stimulus: bank A (3 ch, 32-bit out, SEED=1, on-demand)
//   and bank B (4 ch, 12-bit out, SEED=DEADBEEF, free-running). A cycle-level
//   model of each channel's sequence predicts every output.
module tb_xor_prng_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        seed_load = 1'b0;
    logic [1:0]  seed_ch = '0;
    logic [31:0] seed_value = '0;
    logic        stat_clear = 1'b0;

    logic [2:0]  ready_a = '0;
    logic [2:0]  valid_a;
    logic [95:0] data_a;
    logic [3:0]  ready_b = '0;
    logic [3:0]  valid_b;
    logic [47:0] data_b;
`ifdef XOR_PRNG_STATS_EN
    logic [31:0] cnt_a, cnt_b;
    logic [63:0] sum_a, sum_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    xor_prng_bank #(.NUM_CH(3), .OUT_W(32), .SEED(32'h0000_0001), .FREE_RUN(1'b0)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed_ch(seed_ch),
        .seed_value(seed_value), .rand_valid(valid_a), .rand_ready(ready_a), .rand_data(data_a)
`ifdef XOR_PRNG_STATS_EN
        , .stat_clear(stat_clear), .stat_count(cnt_a), .stat_sum(sum_a)
`endif
    );

    xor_prng_bank #(.NUM_CH(4), .OUT_W(12), .SEED(32'hDEAD_BEEF), .FREE_RUN(1'b1)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load), .seed_ch(seed_ch),
        .seed_value(seed_value), .rand_valid(valid_b), .rand_ready(ready_b), .rand_data(data_b)
`ifdef XOR_PRNG_STATS_EN
        , .stat_clear(stat_clear), .stat_count(cnt_b), .stat_sum(sum_b)
`endif
    );

    // ---------------- reference model ----------------
    logic [31:0] ma[3];
    logic [31:0] mb[4];
    logic        mv;
    logic [31:0] mca, mcb;
    logic [63:0] msa, msb;

    function automatic logic [31:0] m_next(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        y = y ^ (y << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [31:0] m_nz(input logic [31:0] x);
        return (x == 32'd0) ? 32'd1 : x;
    endfunction

    function automatic logic [31:0] m_reset(input logic [31:0] seed, input int c);
        logic [63:0] p;
        p = 64'(c) * 64'h9E37_79B9;
        return m_next(m_nz(seed ^ p[31:0]));
    endfunction

    function automatic logic [95:0] exp_data_a();
        logic [95:0] v;
        for (int c = 0; c < 3; c++) v[c*32 +: 32] = ma[c];
        return v;
    endfunction

    function automatic logic [47:0] exp_data_b();
        logic [47:0] v;
        for (int c = 0; c < 4; c++) v[c*12 +: 12] = mb[c][31:20];
        return v;
    endfunction

    task automatic apply_reset_model();
        for (int c = 0; c < 3; c++) ma[c] = m_reset(32'h0000_0001, c);
        for (int c = 0; c < 4; c++) mb[c] = m_reset(32'hDEAD_BEEF, c);
        mv  = 1'b0;
        mca = '0; mcb = '0; msa = '0; msb = '0;
    endtask

    // One clock edge: predict from current inputs, then step past the edge.
    task automatic cycle();
        logic [31:0] na[3];
        logic [31:0] nb[4];
        logic [31:0] nca, ncb;
        logic [63:0] nsa, nsb;
        for (int c = 0; c < 3; c++) begin
            na[c] = (mv && ready_a[c]) ? m_next(ma[c]) : ma[c];
            if (seed_load && int'(seed_ch) == c) na[c] = m_next(m_nz(seed_value));
        end
        for (int c = 0; c < 4; c++) begin
            nb[c] = (mv && enable) ? m_next(mb[c]) : mb[c];
            if (seed_load && int'(seed_ch) == c) nb[c] = m_next(m_nz(seed_value));
        end
        nca = mca; ncb = mcb; nsa = msa; nsb = msb;
        if (stat_clear) begin
            nca = '0; ncb = '0; nsa = '0; nsb = '0;
        end else begin
            if (mv && ready_a[0]) begin
                if (mca != 32'hFFFF_FFFF) nca = mca + 1;
                nsa = msa + {32'd0, ma[0]};
            end
            if (mv && enable) begin
                if (mcb != 32'hFFFF_FFFF) ncb = mcb + 1;
                nsb = msb + {52'd0, mb[0][31:20]};
            end
        end
        @(posedge clk);
        if (rst) begin
            apply_reset_model();
        end else begin
            for (int c = 0; c < 3; c++) ma[c] = na[c];
            for (int c = 0; c < 4; c++) mb[c] = nb[c];
            mv = enable;
            mca = nca; mcb = ncb; msa = nsa; msb = nsb;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        apply_reset_model();
        #1;
        for (int k = 0; k < 3; k++) begin
            if (valid_a !== 3'b000 || valid_b !== 4'b0000) begin
                n_fail++; $display("FAIL reset_valid: got a=%b b=%b expected 0", valid_a, valid_b);
            end
            n_tests++;
            if (data_a !== exp_data_a()) begin
                n_fail++; $display("FAIL reset_data_a: got %h expected %h", data_a, exp_data_a());
            end
            n_tests++;
            if (data_b !== exp_data_b()) begin
                n_fail++; $display("FAIL reset_data_b: got %h expected %h", data_b, exp_data_b());
            end
            n_tests++;
            if (data_a[31:0] !== 32'h0004_2021) begin
                n_fail++; $display("FAIL reset_ch0_const: got %h expected 00042021", data_a[31:0]);
            end
            n_tests++;
            cycle();
        end
    endtask

    task automatic test_sequence();
        rst = 1'b0;
        enable = 1'b1;
        ready_a = 3'b111;
        ready_b = 4'b0000;
        cycle();
        if (valid_a !== 3'b111 || data_a[31:0] !== 32'h0004_2021) begin
            n_fail++; $display("FAIL seq_first: got v=%b d=%h expected v=111 d=00042021", valid_a, data_a[31:0]);
        end
        n_tests++;
        cycle();
        if (data_a[31:0] !== 32'h0408_0601) begin
            n_fail++; $display("FAIL seq_second: got %h expected 04080601", data_a[31:0]);
        end
        n_tests++;
        for (int k = 0; k < 20; k++) begin
            ready_a = 3'($urandom_range(0, 7));
            cycle();
            if (data_a !== exp_data_a() || valid_a !== {3{mv}}) begin
                n_fail++; $display("FAIL seq_model: got %h expected %h", data_a, exp_data_a());
            end
            n_tests++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold1;
        ready_a = 3'b101;
        cycle();
        hold1 = ma[1];
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (data_a[63:32] !== hold1 || data_a !== exp_data_a()) begin
                n_fail++; $display("FAIL bp_hold: got %h expected ch1 %h all %h", data_a, hold1, exp_data_a());
            end
            n_tests++;
        end
        ready_a = 3'b111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            hold1 = m_next(hold1);
            if (data_a[63:32] !== hold1) begin
                n_fail++; $display("FAIL bp_resume: got %h expected %h", data_a[63:32], hold1);
            end
            n_tests++;
        end
    endtask

    task automatic test_reseed();
        logic [95:0] snap;
        ready_a = 3'b111;
        seed_load = 1'b1; seed_ch = 2'd2; seed_value = 32'd0;
        cycle();
        seed_load = 1'b0;
        if (data_a[95:64] !== 32'h0004_2021 || data_a !== exp_data_a()) begin
            n_fail++; $display("FAIL reseed_zero: got %h expected ch2 00042021 all %h", data_a, exp_data_a());
        end
        n_tests++;
        if (data_b !== exp_data_b()) begin
            n_fail++; $display("FAIL reseed_b: got %h expected %h", data_b, exp_data_b());
        end
        n_tests++;
        ready_a = 3'b000;
        snap = exp_data_a();
        seed_load = 1'b1; seed_ch = 2'd3; seed_value = $urandom;
        cycle();
        seed_load = 1'b0;
        if (data_a !== snap) begin
            n_fail++; $display("FAIL reseed_oor: got %h expected %h", data_a, snap);
        end
        n_tests++;
        if (data_b !== exp_data_b()) begin
            n_fail++; $display("FAIL reseed_b_ch3: got %h expected %h", data_b, exp_data_b());
        end
        n_tests++;
    endtask

    task automatic test_free_run();
        logic [47:0] frozen;
        ready_a = '0; ready_b = '0; enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cycle();
            if (data_b !== exp_data_b() || valid_b !== 4'b1111) begin
                n_fail++; $display("FAIL free_run: got v=%b d=%h expected v=1111 d=%h", valid_b, data_b, exp_data_b());
            end
            n_tests++;
        end
        frozen = exp_data_b();
        enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cycle();
            if (data_b !== frozen || valid_b !== 4'b0000) begin
                n_fail++; $display("FAIL free_stop: got v=%b d=%h expected v=0000 d=%h", valid_b, data_b, frozen);
            end
            n_tests++;
        end
        enable = 1'b1;
        cycle();
    endtask

    task automatic test_random();
        for (int k = 0; k < 300; k++) begin
            enable     = ($urandom_range(0, 9) != 0);
            ready_a    = 3'($urandom_range(0, 7));
            ready_b    = 4'($urandom_range(0, 15));
            seed_load  = ($urandom_range(0, 15) == 0);
            seed_ch    = 2'($urandom_range(0, 3));
            seed_value = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            cycle();
            if (data_a !== exp_data_a() || valid_a !== {3{mv}}) begin
                n_fail++; $display("FAIL rand_a: got v=%b d=%h expected v=%b d=%h", valid_a, data_a, {3{mv}}, exp_data_a());
            end
            n_tests++;
            if (data_b !== exp_data_b() || valid_b !== {4{mv}}) begin
                n_fail++; $display("FAIL rand_b: got v=%b d=%h expected v=%b d=%h", valid_b, data_b, {4{mv}}, exp_data_b());
            end
            n_tests++;
        end
        seed_load = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_midrun_reset();
        ready_a = 3'b111;
        for (int k = 0; k < 100; k++) cycle();
        rst = 1'b1;
        apply_reset_model();
        #1;
        if (valid_a !== 3'b000 || valid_b !== 4'b0000 || data_a !== exp_data_a() || data_b !== exp_data_b()) begin
            n_fail++; $display("FAIL midrun_reset: got va=%b vb=%b a=%h b=%h expected a=%h b=%h",
                               valid_a, valid_b, data_a, data_b, exp_data_a(), exp_data_b());
        end
        n_tests++;
        cycle();
        rst = 1'b0;
        cycle();
        if (valid_a !== 3'b111 || data_a !== exp_data_a() || data_b !== exp_data_b()) begin
            n_fail++; $display("FAIL midrun_release: got va=%b a=%h b=%h expected a=%h b=%h",
                               valid_a, data_a, data_b, exp_data_a(), exp_data_b());
        end
        n_tests++;
    endtask

`ifdef XOR_PRNG_STATS_EN
    task automatic test_stats();
        stat_clear = 1'b1;
        cycle();
        stat_clear = 1'b0;
        if (cnt_a !== 32'd0 || sum_a !== 64'd0 || cnt_b !== 32'd0 || sum_b !== 64'd0) begin
            n_fail++; $display("FAIL stats_clear: got %0d %0d %0d %0d expected 0", cnt_a, sum_a, cnt_b, sum_b);
        end
        n_tests++;
        enable = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            ready_a = 3'($urandom_range(0, 7));
            ready_b = 4'($urandom_range(0, 15));
            cycle();
        end
        if (cnt_a !== mca || sum_a !== msa) begin
            n_fail++; $display("FAIL stats_a: got %0d/%0d expected %0d/%0d", cnt_a, sum_a, mca, msa);
        end
        n_tests++;
        if (cnt_b !== 32'd20000 || sum_b !== msb) begin
            n_fail++; $display("FAIL stats_b: got %0d/%0d expected 20000/%0d", cnt_b, sum_b, msb);
        end
        n_tests++;
        if (sum_b < 64'd39_740_000 || sum_b > 64'd42_160_000) begin
            n_fail++; $display("FAIL stats_mean: got sum %0d expected mean near 2047.5 over 20000", sum_b);
        end
        n_tests++;
        // Clear on the same edge as an acceptance must win.
        ready_a = 3'b111;
        stat_clear = 1'b1;
        cycle();
        stat_clear = 1'b0;
        if (cnt_a !== 32'd0 || sum_a !== 64'd0 || cnt_b !== 32'd0 || sum_b !== 64'd0) begin
            n_fail++; $display("FAIL stats_clear_wins: got %0d %0d %0d %0d expected 0", cnt_a, sum_a, cnt_b, sum_b);
        end
        n_tests++;
        cycle();
        if (cnt_a !== 32'd1 || sum_a !== msa || cnt_b !== 32'd1 || sum_b !== msb) begin
            n_fail++; $display("FAIL stats_after_clear: got %0d/%0d %0d/%0d expected 1/%0d 1/%0d",
                               cnt_a, sum_a, cnt_b, sum_b, msa, msb);
        end
        n_tests++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_sequence();
        test_backpressure();
        test_reseed();
        test_free_run();
        test_random();
        test_midrun_reset();
`ifdef XOR_PRNG_STATS_EN
        test_stats();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
